clint_axi_master: RTL
=====================

# clint_axi_master

Single-outstanding AXI4 write/read initiator. It converts a simple valid/ready request port into single-beat AXI transactions and returns one response per request. It sits between the core's MMIO path and the CLINT AXI slave (MSIP/SSIP registers at 0x0200_0000 / 0x0200_C000). It replaces the behavioural bench agent as the RTL driver of that slave.

## Interface
- ADDR_W, 32, request/AXI address width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with CLINT_AXI_MST_TIMEOUT_EN
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address, word aligned
- req_wdata  in  32  write data
- req_wstrb  in  4  byte strobes
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  SLVERR/DECERR received, or timeout
- awaddr  out  ADDR_W  write address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wlast  out  1  constant 1; single beat
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bresp  in  2  write response
- bvalid  in  1  write response valid
- bready  out  1  write response ready
- araddr  out  ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  32  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- The integrator ties the slave-side signals at top level: awlen/arlen = 0, awsize/arsize = 3'b010, burst INCR, ids 0.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- req_ready = (state == IDLE). A request is accepted on req_valid & req_ready. Address, data and strobes are registered at acceptance.
- IDLE to WR_REQ (req_we = 1):
  - awvalid and wvalid are raised together.
  - Each drops independently on its own handshake; pending flags track aw_done and w_done.
  - Leave for WR_RESP in the cycle both handshakes are done, including when both complete in the same cycle.
- WR_RESP:
  - bready = 1.
  - On bvalid: rsp_valid pulses, rsp_err = bresp[1], rsp_rdata = 0, then IDLE.
- IDLE to RD_REQ (req_we = 0):
  - arvalid is held until arready, then RD_RESP.
- RD_RESP:
  - rready = 1.
  - On rvalid: rsp_valid pulses, rsp_rdata = rdata, rsp_err = rresp[1], then IDLE.
- AXI valids never drop before their handshake. Address, data and strobe outputs stay stable while valid.
- bvalid or rvalid arriving outside its response state is ignored and not acknowledged.

## Timing
- Reset values: every output 0 except wlast = 1. State is IDLE, so req_ready = 1 from the first cycle after rst_ni deasserts.
- Cycle 0 is request acceptance. awvalid/wvalid (or arvalid) are registered and high in cycle 1.
- Against a zero-wait slave:
  - aw/w handshake in cycle 1.
  - bvalid sampled in cycle 2.
  - rsp_valid high in cycle 3.
  - The next req_ready is in cycle 3. rsp_valid and req_ready coincide in that cycle, so a new request can be accepted in the same cycle the response pulses.
- Read latency is identical: ar handshake in cycle 1, rsp_valid in cycle 3.
- rsp_* are registered, valid only while rsp_valid = 1, and hold their last values otherwise.
- rst_ni asserted mid-transaction clears all valids and readies asynchronously. No response is generated for the aborted request.

## Configuration
- CLINT_AXI_MST_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on acceptance and increments every non-IDLE cycle.
  - When it reaches TIMEOUT_CYCLES: all AXI valids/readies drop, rsp_valid pulses with rsp_err = 1 and rsp_rdata = 0, and state returns to IDLE.
  - This is a deliberate debug-only AXI violation.
- Not defined: no counter, and the block waits indefinitely for the slave.

## Test plan
- Write 0x0000_0001 to 0x0200_0000 with strobe 0xF, zero-wait slave -> rsp_valid 3 cycles after acceptance, rsp_err = 0, CLINT mipi0_o = 1.
- Read 0x0200_0000 after that write -> rsp_rdata = 0x0000_0001, rsp_err = 0. Then write 0 to 0x0200_C004 -> sipi1_o = 0.
- Write with wready immediate and awready delayed 3 cycles -> wvalid high for exactly 1 cycle, awvalid held 4 cycles, exactly one rsp_valid, bready only in WR_RESP.
- Slave returns bresp = 2'b10, then rresp = 2'b11 on a following read -> rsp_err = 1 for both, state returns to IDLE, req_ready = 1.
- With macro defined, TIMEOUT_CYCLES = 16, slave holds arready = 0 -> arvalid drops and rsp_valid with rsp_err = 1 in cycle 16 after acceptance. Without the macro -> no response after 1000 cycles.
- rst_ni pulsed low while in WR_RESP -> all outputs at reset values immediately, no rsp_valid, and the next request completes normally.

Source files
------------

// File: rtl/clint_axi_master_if.sv
// clint_axi_master_if: request/response port plus AXI4-lite-style channels between the initiator and the CLINT slave.
interface clint_axi_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready
  );
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready
  );
endinterface

// File: rtl/clint_axi_master.sv
// clint_axi_master: single-outstanding initiator turning valid/ready requests into single-beat AXI reads/writes.
// Define CLINT_AXI_MST_TIMEOUT_EN to abort a stalled transaction with an error response after TIMEOUT_CYCLES.
module clint_axi_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                clk_i,
  input logic                rst_ni,
  clint_axi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic              ready_q, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              accept, timeout, unused_resp;
  assign accept      = bus.req_valid & ready_q;
  assign unused_resp = ^{bus.bresp[0], bus.rresp[0]};
`ifdef CLINT_AXI_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // Decided one cycle ahead so the registered error response lands TIMEOUT_CYCLES after acceptance.
  assign timeout = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 2));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= accept ? '0 : (state_q != IDLE) ? cnt_q + 1'b1 : cnt_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    addr_d      = accept ? bus.req_addr : addr_q;
    wdata_d     = accept ? bus.req_wdata : wdata_q;
    wstrb_d     = accept ? bus.req_wstrb : wstrb_q;
    awvalid_d   = accept ? bus.req_we : awvalid_q & ~bus.awready;
    wvalid_d    = accept ? bus.req_we : wvalid_q & ~bus.wready;
    arvalid_d   = accept ? ~bus.req_we : arvalid_q & ~bus.arready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.req_we ? WR_REQ : RD_REQ;
      WR_REQ:  if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      WR_RESP: if (bus.bvalid) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = bus.bresp[1];
      end
      RD_REQ:  if (!arvalid_d) state_d = RD_RESP;
      RD_RESP: if (bus.rvalid) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus.rdata;
        rsp_err_d   = bus.rresp[1];
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d     = IDLE;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      ready_q     <= state_d == IDLE;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.awaddr    = addr_q;
  assign bus.araddr    = addr_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.wlast     = 1'b1;
  assign bus.bready    = state_q == WR_RESP;
  assign bus.rready    = state_q == RD_RESP;
endmodule
